// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Central stall/flush control for the 5-stage MIPS pipeline, with
//            data-wait freeze, sticky halt and a data-wait watchdog.
//            Optional statistics counters enabled by HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] idrs,
    input  logic [4:0] idrt,
    input  logic [4:0] exrt,
    input  logic       exDRE,
    input  logic       exbrnch_taken,
    input  logic       exjmp,
    input  logic       memDRE,
    input  logic       memDWE,
    input  logic       memHALT,
    output logic       pcW,
    output logic       ifidW,
    output logic       ifidRST,
    output logic       idW,
    output logic       idRST,
    output logic       exmemW,
    output logic       exmemRST,
    output logic       memwbW,
    output logic       halt,
    output logic       mem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DWAIT  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;

    logic w_halted;
    logic w_mem_wait;
    logic w_redirect;
    logic w_load_use;
    logic w_fetch_miss;

    logic w_pcW, w_ifidW, w_ifidRST, w_idW, w_idRST, w_exmemW, w_memwbW;

    assign w_halted     = (state_q == ST_HALTED);
    assign w_mem_wait   = (memDRE | memDWE) & ~dhit;
    assign w_redirect   = exbrnch_taken | exjmp;
    assign w_load_use   = exDRE && (exrt != 5'd0) && ((exrt == idrs) || (exrt == idrt));
    assign w_fetch_miss = ~ihit;

    // Strobe decode: priority is halted > data wait > redirect > load-use > fetch miss.
    always_comb begin
        w_pcW     = 1'b1;
        w_ifidW   = 1'b1;
        w_ifidRST = 1'b0;
        w_idW     = 1'b1;
        w_idRST   = 1'b0;
        w_exmemW  = 1'b1;
        w_memwbW  = 1'b1;
        if (w_halted || w_mem_wait) begin
            w_pcW    = 1'b0;
            w_ifidW  = 1'b0;
            w_idW    = 1'b0;
            w_exmemW = 1'b0;
            w_memwbW = 1'b0;
        end else if (w_redirect) begin
            w_ifidRST = 1'b1;
            w_idRST   = 1'b1;
        end else if (w_load_use) begin
            w_pcW   = 1'b0;
            w_ifidW = 1'b0;
            w_idRST = 1'b1;
        end else if (w_fetch_miss) begin
            w_pcW     = 1'b0;
            w_ifidRST = 1'b1;
        end
    end

    // Next state and watchdog; the counter only runs across consecutive DWAIT cycles.
    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        case (state_q)
            ST_HALTED: state_d = ST_HALTED;
            default: begin
                if (w_mem_wait) begin
                    state_d = ST_DWAIT;
                    if (state_q == ST_DWAIT) begin
                        wd_cnt_d = (wd_cnt_q == C_CNT_MAX) ? wd_cnt_q : (wd_cnt_q + C_CNT_ONE);
                    end
                end else if (memHALT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        if ((state_d == ST_DWAIT) && (wd_cnt_d >= C_TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Every output is forced low for as long as reset is held.
    assign pcW         = w_pcW     & ~RST;
    assign ifidW       = w_ifidW   & ~RST;
    assign ifidRST     = w_ifidRST & ~RST;
    assign idW         = w_idW     & ~RST;
    assign idRST       = w_idRST   & ~RST;
    assign exmemW      = w_exmemW  & ~RST;
    assign exmemRST    = 1'b0;
    assign memwbW      = w_memwbW  & ~RST;
    assign halt        = w_halted  & ~RST;
    assign mem_timeout = timeout_q & ~RST;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             w_stall_ev, w_flush_ev, w_bubble_ev;

    assign w_stall_ev  = ~w_halted & w_mem_wait;
    assign w_flush_ev  = ~w_halted & ~w_mem_wait & w_redirect;
    assign w_bubble_ev = ~w_halted & ~w_mem_wait & ~w_redirect & (w_load_use | w_fetch_miss);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (w_stall_ev && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
        if (w_flush_ev && (flush_cnt_q != C_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + C_CNT_ONE;
        end
        if (w_bubble_ev && (bubble_cnt_q != C_CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: vector table, directed
//            multi-cycle sequences and randomized traffic vs a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 8;

    logic       CLK, RST;
    logic       ihit, dhit, exDRE, exbrnch_taken, exjmp, memDRE, memDWE, memHALT;
    logic [4:0] idrs, idrt, exrt;
    logic       pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW, halt, mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;
`endif

    hazard_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .idrs(idrs), .idrt(idrt), .exrt(exrt), .exDRE(exDRE),
        .exbrnch_taken(exbrnch_taken), .exjmp(exjmp),
        .memDRE(memDRE), .memDWE(memDWE), .memHALT(memHALT),
        .pcW(pcW), .ifidW(ifidW), .ifidRST(ifidRST), .idW(idW), .idRST(idRST),
        .exmemW(exmemW), .exmemRST(exmemRST), .memwbW(memwbW),
        .halt(halt), .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic [4:0] idrs;
        logic [4:0] idrt;
        logic [4:0] exrt;
        logic       exDRE;
        logic       br;
        logic       jmp;
        logic       mDRE;
        logic       mDWE;
        logic       mHALT;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    // Strobe order: {pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW}
    localparam logic [7:0] E_NORM   = 8'b1101_0101;
    localparam logic [7:0] E_LU     = 8'b0001_1101;
    localparam logic [7:0] E_REDIR  = 8'b1111_1101;
    localparam logic [7:0] E_MISS   = 8'b0111_0101;
    localparam logic [7:0] E_FROZEN = 8'b0000_0000;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DWAIT  = 2'd1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: halted flag, length of the current data-wait run, sticky timeout.
    bit m_halted;
    int m_streak;
    bit m_timeout;

    function automatic stim_t mk(input logic ih, input logic dh, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] xrt, input logic dre,
                                 input logic b, input logic j, input logic mr, input logic mw,
                                 input logic mh);
        stim_t s;
        s.ihit = ih; s.dhit = dh; s.idrs = rs; s.idrt = rt; s.exrt = xrt; s.exDRE = dre;
        s.br = b; s.jmp = j; s.mDRE = mr; s.mDWE = mw; s.mHALT = mh;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.ihit  = ($urandom_range(99) < 75);
        s.dhit  = ($urandom_range(99) < 60);
        s.idrs  = 5'($urandom_range(7));
        s.idrt  = 5'($urandom_range(7));
        s.exrt  = 5'($urandom_range(7));
        s.exDRE = ($urandom_range(99) < 40);
        s.br    = ($urandom_range(99) < 15);
        s.jmp   = ($urandom_range(99) < 8);
        s.mDRE  = ($urandom_range(99) < 25);
        s.mDWE  = ($urandom_range(99) < 15);
        s.mHALT = ($urandom_range(99) < 2);
        return s;
    endfunction

    function automatic logic [9:0] model_out(input stim_t s, input logic r);
        bit         waiting, lu;
        logic [7:0] st;
        if (r) return 10'd0;
        waiting = (s.mDRE || s.mDWE) && !s.dhit;
        lu      = s.exDRE && (s.exrt != 0) && (s.exrt == s.idrs || s.exrt == s.idrt);
        if (m_halted || waiting) st = E_FROZEN;
        else if (s.br || s.jmp)  st = E_REDIR;
        else if (lu)             st = E_LU;
        else if (!s.ihit)        st = E_MISS;
        else                     st = E_NORM;
        return {st, logic'(m_halted), logic'(m_timeout)};
    endfunction

    task automatic model_reset();
        m_halted  = 0;
        m_streak  = 0;
        m_timeout = 0;
    endtask

    task automatic model_update(input stim_t s, input logic r);
        if (r || m_halted) return;
        if ((s.mDRE || s.mDWE) && !s.dhit) begin
            m_streak++;
            // Cycles actually spent in DWAIT exclude the cycle that entered it.
            if (m_streak - 1 >= TB_TIMEOUT) m_timeout = 1;
        end else begin
            m_streak = 0;
            if (s.mHALT) m_halted = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {pcW, ifidW, ifidRST, idW, idRST, exmemW, exmemRST, memwbW};
    endfunction

    // One clock cycle: drive after the falling edge, compare mid-cycle, advance model on the rising edge.
    task automatic step(input stim_t s, input logic r, input string name,
                        input bit has_exp, input logic [7:0] exp);
        RST = r;
        ihit = s.ihit; dhit = s.dhit; idrs = s.idrs; idrt = s.idrt; exrt = s.exrt;
        exDRE = s.exDRE; exbrnch_taken = s.br; exjmp = s.jmp;
        memDRE = s.mDRE; memDWE = s.mDWE; memHALT = s.mHALT;
        if (r) model_reset();
        #1;
        check({name, "_model"}, {22'd0, strobes(), halt, mem_timeout}, {22'd0, model_out(s, r)});
        if (has_exp) check({name, "_strobes"}, {24'd0, strobes()}, {24'd0, exp});
        @(posedge CLK);
        model_update(s, r);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        step(mk(1,1,0,0,0,0,0,0,0,0,0), 1'b1, "reset", 1'b1, E_FROZEN);
    endtask

    vec_t  vecs[$];
    stim_t idle, wait_s;

    initial begin
        idle   = mk(1,1,0,0,0,0,0,0,0,0,0);
        wait_s = mk(1,0,0,0,0,0,0,0,1,0,0);
        RST = 1'b1;
        ihit = 1'b1; dhit = 1'b1; idrs = '0; idrt = '0; exrt = '0; exDRE = 1'b0;
        exbrnch_taken = 1'b0; exjmp = 1'b0; memDRE = 1'b0; memDWE = 1'b0; memHALT = 1'b0;
        model_reset();

        vecs.push_back('{"idle",          mk(1,1,0,0,0,0,0,0,0,0,0), E_NORM});
        vecs.push_back('{"lu_rs",         mk(1,1,5,0,5,1,0,0,0,0,0), E_LU});
        vecs.push_back('{"lu_r0",         mk(1,1,0,0,0,1,0,0,0,0,0), E_NORM});
        vecs.push_back('{"lu_rt",         mk(1,1,3,7,7,1,0,0,0,0,0), E_LU});
        vecs.push_back('{"match_no_load", mk(1,1,5,5,5,0,0,0,0,0,0), E_NORM});
        vecs.push_back('{"br_miss",       mk(0,1,0,0,0,0,1,0,0,0,0), E_REDIR});
        vecs.push_back('{"br_miss_lu",    mk(0,1,5,0,5,1,1,0,0,0,0), E_REDIR});
        vecs.push_back('{"jmp",           mk(1,1,0,0,0,0,0,1,0,0,0), E_REDIR});
        vecs.push_back('{"miss",          mk(0,1,0,0,0,0,0,0,0,0,0), E_MISS});
        vecs.push_back('{"miss_lu",       mk(0,1,9,0,9,1,0,0,0,0,0), E_LU});
        vecs.push_back('{"dre_hit",       mk(1,1,0,0,0,0,0,0,1,1,0), E_NORM});

        @(negedge CLK);
        do_reset();
        check("reset_state", 32'(dut.state_q), 32'(S_RUN));
        check("reset_wd", 32'(dut.wd_cnt_q), 0);

        foreach (vecs[i]) step(vecs[i].s, 1'b0, vecs[i].name, 1'b1, vecs[i].exp);

        // Data wait: three frozen cycles, then release on dhit.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(wait_s, 1'b0, "dwait", 1'b1, E_FROZEN);
            check("dwait_state", 32'(dut.state_q), 32'(S_DWAIT));
        end
        step(mk(1,1,0,0,0,0,0,0,1,0,0), 1'b0, "dwait_done", 1'b1, E_NORM);
        check("dwait_exit_state", 32'(dut.state_q), 32'(S_RUN));

        // Watchdog trips once four cycles have been spent in DWAIT.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(wait_s, 1'b0, "wd", 1'b1, E_FROZEN);
            check("wd_cnt", 32'(dut.wd_cnt_q), i);
            check("wd_timeout", {31'd0, mem_timeout}, (i >= 4) ? 1 : 0);
        end
        step(mk(1,1,0,0,0,0,0,0,1,0,0), 1'b0, "wd_release", 1'b1, E_NORM);
        check("wd_sticky", {31'd0, mem_timeout}, 1);
        check("wd_clear", 32'(dut.wd_cnt_q), 0);

        // Halt capture, hold, and recovery by reset.
        do_reset();
        step(mk(1,1,0,0,0,0,0,0,0,0,1), 1'b0, "halt_cap", 1'b1, E_NORM);
        for (int i = 0; i < 10; i++) begin
            step(rand_stim(), 1'b0, "halted", 1'b1, E_FROZEN);
            check("halt_level", {31'd0, halt}, 1);
        end
        do_reset();
        check("halt_cleared", {31'd0, halt}, 0);
        step(idle, 1'b0, "post_halt", 1'b1, E_NORM);
        check("post_halt_state", 32'(dut.state_q), 32'(S_RUN));

        // Reset asserted in the middle of a data wait.
        do_reset();
        for (int i = 0; i < 3; i++) step(wait_s, 1'b0, "pre_rst_wait", 1'b0, E_FROZEN);
        step(wait_s, 1'b1, "rst_mid_wait", 1'b1, E_FROZEN);
        check("rst_mid_state", 32'(dut.state_q), 32'(S_RUN));
        step(idle, 1'b0, "rst_release", 1'b1, E_NORM);
        check("rst_release_state", 32'(dut.state_q), 32'(S_RUN));
        check("rst_release_wd", 32'(dut.wd_cnt_q), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            step(rand_stim(), logic'($urandom_range(99) < 3), "rand", 1'b0, E_NORM);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
